// File: rtl/e203_itcm_icb_arbt.sv
// ITCM ICB arbiter: round-robin IFU/LSU command mux with grant lock,
// plus an in-order source FIFO steering ITCM responses to their owner.
module e203_itcm_icb_arbt #(
  parameter int AW     = 16,
  parameter int DW     = 64,
  parameter int OUTS_N = 2
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            ifu_icb_cmd_valid,
  output logic            ifu_icb_cmd_ready,
  input  logic [AW-1:0]   ifu_icb_cmd_addr,
  output logic            ifu_icb_rsp_valid,
  input  logic            ifu_icb_rsp_ready,
  output logic            ifu_icb_rsp_err,
  output logic [DW-1:0]   ifu_icb_rsp_rdata,

  input  logic            lsu_icb_cmd_valid,
  output logic            lsu_icb_cmd_ready,
  input  logic [AW-1:0]   lsu_icb_cmd_addr,
  input  logic            lsu_icb_cmd_read,
  input  logic [DW-1:0]   lsu_icb_cmd_wdata,
  input  logic [DW/8-1:0] lsu_icb_cmd_wmask,
  output logic            lsu_icb_rsp_valid,
  input  logic            lsu_icb_rsp_ready,
  output logic            lsu_icb_rsp_err,
  output logic [DW-1:0]   lsu_icb_rsp_rdata,

  output logic            itcm_icb_cmd_valid,
  input  logic            itcm_icb_cmd_ready,
  output logic [AW-1:0]   itcm_icb_cmd_addr,
  output logic            itcm_icb_cmd_read,
  output logic [DW-1:0]   itcm_icb_cmd_wdata,
  output logic [DW/8-1:0] itcm_icb_cmd_wmask,
  input  logic            itcm_icb_rsp_valid,
  output logic            itcm_icb_rsp_ready,
  input  logic            itcm_icb_rsp_err,
  input  logic [DW-1:0]   itcm_icb_rsp_rdata
);

  localparam int MW = DW / 8;
  localparam int PW = (OUTS_N > 1) ? $clog2(OUTS_N) : 1;
  localparam int CW = $clog2(OUTS_N + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTS_N);
  localparam logic [PW-1:0] LAST_PTR = PW'(OUTS_N - 1);

  typedef enum logic {
    SRC_IFU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  src_e          last_grant;
  src_e          lock_grant;
  src_e          arb_grant;
  src_e          grant;
  logic          lock;

  src_e          src_q [OUTS_N];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  src_e          head;

  logic          req;
  logic          cmd_hs;
  logic          rsp_hs;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign head  = src_q[rptr];

  // Reset leaves last_grant at LSU so IFU wins the first tie.
  always_comb begin
    arb_grant = SRC_IFU;
    unique case (1'b1)
      ifu_icb_cmd_valid & lsu_icb_cmd_valid:
        arb_grant = (last_grant == SRC_LSU)
                  ? SRC_IFU : SRC_LSU;
      lsu_icb_cmd_valid & ~ifu_icb_cmd_valid:
        arb_grant = SRC_LSU;
      default:
        arb_grant = SRC_IFU;
    endcase
  end

  assign grant = lock ? lock_grant : arb_grant;

  always_comb begin
    req                = 1'b0;
    ifu_icb_cmd_ready  = 1'b0;
    lsu_icb_cmd_ready  = 1'b0;
    itcm_icb_cmd_addr  = '0;
    itcm_icb_cmd_read  = 1'b1;
    itcm_icb_cmd_wdata = '0;
    itcm_icb_cmd_wmask = '0;
    if (grant == SRC_LSU) begin
      req                = lsu_icb_cmd_valid;
      lsu_icb_cmd_ready  = itcm_icb_cmd_ready & ~full;
      itcm_icb_cmd_addr  = lsu_icb_cmd_addr;
      itcm_icb_cmd_read  = lsu_icb_cmd_read;
      itcm_icb_cmd_wdata = lsu_icb_cmd_wdata;
      itcm_icb_cmd_wmask = lsu_icb_cmd_wmask;
    end else begin
      req                = ifu_icb_cmd_valid;
      ifu_icb_cmd_ready  = itcm_icb_cmd_ready & ~full;
      itcm_icb_cmd_addr  = ifu_icb_cmd_addr;
    end
  end

  assign itcm_icb_cmd_valid = req & ~full;
  assign cmd_hs = itcm_icb_cmd_valid & itcm_icb_cmd_ready;

  // Responses with no outstanding entry are left unacknowledged.
  always_comb begin
    ifu_icb_rsp_valid  = 1'b0;
    lsu_icb_rsp_valid  = 1'b0;
    itcm_icb_rsp_ready = 1'b0;
    if (!empty) begin
      if (head == SRC_LSU) begin
        lsu_icb_rsp_valid  = itcm_icb_rsp_valid;
        itcm_icb_rsp_ready = lsu_icb_rsp_ready;
      end else begin
        ifu_icb_rsp_valid  = itcm_icb_rsp_valid;
        itcm_icb_rsp_ready = ifu_icb_rsp_ready;
      end
    end
  end

  assign ifu_icb_rsp_err   = itcm_icb_rsp_err;
  assign ifu_icb_rsp_rdata = itcm_icb_rsp_rdata;
  assign lsu_icb_rsp_err   = itcm_icb_rsp_err;
  assign lsu_icb_rsp_rdata = itcm_icb_rsp_rdata;

  assign rsp_hs = itcm_icb_rsp_valid & itcm_icb_rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= SRC_LSU;
      lock_grant <= SRC_IFU;
      lock       <= 1'b0;
    end else begin
      if (cmd_hs) begin
        last_grant <= grant;
        lock       <= 1'b0;
      end else if (itcm_icb_cmd_valid) begin
        lock       <= 1'b1;
        lock_grant <= grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (cmd_hs)
        wptr <= ptr_inc(wptr);
      if (rsp_hs)
        rptr <= ptr_inc(rptr);
      unique case ({cmd_hs, rsp_hs})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_hs)
      src_q[wptr] <= grant;
  end

  logic unused_mw;
  assign unused_mw = (MW == 0);

endmodule

// File: tb/tb_e203_itcm_icb_arbt.sv
// Directed bench for e203_itcm_icb_arbt: arbitration, lock,
// FIFO full blocking, response routing and mid-run reset.
module tb_e203_itcm_icb_arbt;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_icb_cmd_valid;
  logic        ifu_icb_cmd_ready;
  logic [15:0] ifu_icb_cmd_addr;
  logic        ifu_icb_rsp_valid;
  logic        ifu_icb_rsp_ready;
  logic        ifu_icb_rsp_err;
  logic [63:0] ifu_icb_rsp_rdata;
  logic        lsu_icb_cmd_valid;
  logic        lsu_icb_cmd_ready;
  logic [15:0] lsu_icb_cmd_addr;
  logic        lsu_icb_cmd_read;
  logic [63:0] lsu_icb_cmd_wdata;
  logic [7:0]  lsu_icb_cmd_wmask;
  logic        lsu_icb_rsp_valid;
  logic        lsu_icb_rsp_ready;
  logic        lsu_icb_rsp_err;
  logic [63:0] lsu_icb_rsp_rdata;
  logic        itcm_icb_cmd_valid;
  logic        itcm_icb_cmd_ready;
  logic [15:0] itcm_icb_cmd_addr;
  logic        itcm_icb_cmd_read;
  logic [63:0] itcm_icb_cmd_wdata;
  logic [7:0]  itcm_icb_cmd_wmask;
  logic        itcm_icb_rsp_valid;
  logic        itcm_icb_rsp_ready;
  logic        itcm_icb_rsp_err;
  logic [63:0] itcm_icb_rsp_rdata;

  int errors = 0;
  int checks = 0;

  e203_itcm_icb_arbt dut (
    .clk(clk), .rst(rst),
    .ifu_icb_cmd_valid(ifu_icb_cmd_valid),
    .ifu_icb_cmd_ready(ifu_icb_cmd_ready),
    .ifu_icb_cmd_addr(ifu_icb_cmd_addr),
    .ifu_icb_rsp_valid(ifu_icb_rsp_valid),
    .ifu_icb_rsp_ready(ifu_icb_rsp_ready),
    .ifu_icb_rsp_err(ifu_icb_rsp_err),
    .ifu_icb_rsp_rdata(ifu_icb_rsp_rdata),
    .lsu_icb_cmd_valid(lsu_icb_cmd_valid),
    .lsu_icb_cmd_ready(lsu_icb_cmd_ready),
    .lsu_icb_cmd_addr(lsu_icb_cmd_addr),
    .lsu_icb_cmd_read(lsu_icb_cmd_read),
    .lsu_icb_cmd_wdata(lsu_icb_cmd_wdata),
    .lsu_icb_cmd_wmask(lsu_icb_cmd_wmask),
    .lsu_icb_rsp_valid(lsu_icb_rsp_valid),
    .lsu_icb_rsp_ready(lsu_icb_rsp_ready),
    .lsu_icb_rsp_err(lsu_icb_rsp_err),
    .lsu_icb_rsp_rdata(lsu_icb_rsp_rdata),
    .itcm_icb_cmd_valid(itcm_icb_cmd_valid),
    .itcm_icb_cmd_ready(itcm_icb_cmd_ready),
    .itcm_icb_cmd_addr(itcm_icb_cmd_addr),
    .itcm_icb_cmd_read(itcm_icb_cmd_read),
    .itcm_icb_cmd_wdata(itcm_icb_cmd_wdata),
    .itcm_icb_cmd_wmask(itcm_icb_cmd_wmask),
    .itcm_icb_rsp_valid(itcm_icb_rsp_valid),
    .itcm_icb_rsp_ready(itcm_icb_rsp_ready),
    .itcm_icb_rsp_err(itcm_icb_rsp_err),
    .itcm_icb_rsp_rdata(itcm_icb_rsp_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifu_icb_cmd_valid  = 1'b0;
    ifu_icb_cmd_addr   = '0;
    ifu_icb_rsp_ready  = 1'b0;
    lsu_icb_cmd_valid  = 1'b0;
    lsu_icb_cmd_addr   = '0;
    lsu_icb_cmd_read   = 1'b1;
    lsu_icb_cmd_wdata  = '0;
    lsu_icb_cmd_wmask  = '0;
    lsu_icb_rsp_ready  = 1'b0;
    itcm_icb_cmd_ready = 1'b0;
    itcm_icb_rsp_valid = 1'b0;
    itcm_icb_rsp_err   = 1'b0;
    itcm_icb_rsp_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    #1;
    checks++; if (itcm_icb_cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid got=%b exp=0", itcm_icb_cmd_valid); end
    checks++; if (ifu_icb_cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ifu_rdy got=%b exp=0", ifu_icb_cmd_ready); end
    checks++; if (lsu_icb_cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_lsu_rdy got=%b exp=0", lsu_icb_cmd_ready); end
    checks++; if (ifu_icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_ifu_rspv got=%b exp=0", ifu_icb_rsp_valid); end
    checks++; if (lsu_icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_lsu_rspv got=%b exp=0", lsu_icb_rsp_valid); end
    checks++; if (itcm_icb_rsp_ready !== 1'b0) begin errors++; $display("FAIL rst_rsp_rdy got=%b exp=0", itcm_icb_rsp_ready); end
    checks++; if (itcm_icb_cmd_addr !== 16'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", itcm_icb_cmd_addr); end
    checks++; if (itcm_icb_cmd_wdata !== 64'h0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", itcm_icb_cmd_wdata); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_round_robin();
    logic prev_lsu;
    logic cur_lsu;
    idle();
    ifu_icb_rsp_ready  = 1'b1;
    lsu_icb_rsp_ready  = 1'b1;
    itcm_icb_cmd_ready = 1'b1;
    ifu_icb_cmd_addr   = 16'h0010;
    lsu_icb_cmd_addr   = 16'h0200;
    for (int k = 0; k < 5; k++) begin
      ifu_icb_cmd_valid  = (k < 4);
      lsu_icb_cmd_valid  = (k < 4);
      itcm_icb_rsp_valid = (k > 0);
      itcm_icb_rsp_rdata = 64'h1000 + 64'(k);
      #1;
      if (k < 4) begin
        cur_lsu = (k % 2 == 1);
        checks++; if (ifu_icb_cmd_ready !== !cur_lsu) begin errors++; $display("FAIL rr_ifu_rdy k=%0d got=%b exp=%b", k, ifu_icb_cmd_ready, !cur_lsu); end
        checks++; if (lsu_icb_cmd_ready !== cur_lsu) begin errors++; $display("FAIL rr_lsu_rdy k=%0d got=%b exp=%b", k, lsu_icb_cmd_ready, cur_lsu); end
        checks++; if (itcm_icb_cmd_addr !== (cur_lsu ? 16'h0200 : 16'h0010)) begin errors++; $display("FAIL rr_addr k=%0d got=%h", k, itcm_icb_cmd_addr); end
      end
      if (k > 0) begin
        prev_lsu = ((k - 1) % 2 == 1);
        checks++; if (ifu_icb_rsp_valid !== !prev_lsu) begin errors++; $display("FAIL rr_ifu_rspv k=%0d got=%b exp=%b", k, ifu_icb_rsp_valid, !prev_lsu); end
        checks++; if (lsu_icb_rsp_valid !== prev_lsu) begin errors++; $display("FAIL rr_lsu_rspv k=%0d got=%b exp=%b", k, lsu_icb_rsp_valid, prev_lsu); end
        checks++; if (itcm_icb_rsp_ready !== 1'b1) begin errors++; $display("FAIL rr_rsp_rdy k=%0d got=%b exp=1", k, itcm_icb_rsp_ready); end
        checks++; if (lsu_icb_rsp_rdata !== 64'h1000 + 64'(k)) begin errors++; $display("FAIL rr_rdata k=%0d got=%h", k, lsu_icb_rsp_rdata); end
      end
      cyc();
    end
    itcm_icb_rsp_valid = 1'b0;
    #1;
    checks++; if (itcm_icb_rsp_ready !== 1'b0) begin errors++; $display("FAIL rr_empty_rdy got=%b exp=0", itcm_icb_rsp_ready); end
    idle();
  endtask

  task automatic test_lock();
    idle();
    ifu_icb_rsp_ready  = 1'b1;
    lsu_icb_rsp_ready  = 1'b1;
    ifu_icb_cmd_valid  = 1'b1;
    ifu_icb_cmd_addr   = 16'h0040;
    itcm_icb_cmd_ready = 1'b1;
    #1;
    checks++; if (ifu_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL lk_pre_rdy got=%b exp=1", ifu_icb_cmd_ready); end
    cyc();
    ifu_icb_cmd_valid  = 1'b0;
    itcm_icb_rsp_valid = 1'b1;
    #1;
    checks++; if (ifu_icb_rsp_valid !== 1'b1) begin errors++; $display("FAIL lk_pre_rspv got=%b exp=1", ifu_icb_rsp_valid); end
    cyc();
    itcm_icb_rsp_valid = 1'b0;
    ifu_icb_cmd_addr   = 16'h0010;
    lsu_icb_cmd_addr   = 16'h0200;
    ifu_icb_cmd_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      lsu_icb_cmd_valid  = (k > 0);
      itcm_icb_cmd_ready = (k == 3);
      #1;
      checks++; if (itcm_icb_cmd_addr !== 16'h0010) begin errors++; $display("FAIL lk_addr k=%0d got=%h exp=0010", k, itcm_icb_cmd_addr); end
      checks++; if (lsu_icb_cmd_ready !== 1'b0) begin errors++; $display("FAIL lk_lsu_rdy k=%0d got=%b exp=0", k, lsu_icb_cmd_ready); end
      checks++; if (ifu_icb_cmd_ready !== (k == 3)) begin errors++; $display("FAIL lk_ifu_rdy k=%0d got=%b", k, ifu_icb_cmd_ready); end
      cyc();
    end
    ifu_icb_cmd_valid  = 1'b0;
    itcm_icb_rsp_valid = 1'b1;
    #1;
    checks++; if (lsu_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL lk_after_lsu got=%b exp=1", lsu_icb_cmd_ready); end
    checks++; if (ifu_icb_rsp_valid !== 1'b1) begin errors++; $display("FAIL lk_ifu_rspv got=%b exp=1", ifu_icb_rsp_valid); end
    cyc();
    lsu_icb_cmd_valid = 1'b0;
    #1;
    checks++; if (lsu_icb_rsp_valid !== 1'b1) begin errors++; $display("FAIL lk_lsu_rspv got=%b exp=1", lsu_icb_rsp_valid); end
    cyc();
    idle();
  endtask

  task automatic test_full();
    idle();
    ifu_icb_rsp_ready  = 1'b1;
    ifu_icb_cmd_valid  = 1'b1;
    ifu_icb_cmd_addr   = 16'h0020;
    itcm_icb_cmd_ready = 1'b1;
    #1;
    checks++; if (ifu_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL fu_c0 got=%b exp=1", ifu_icb_cmd_ready); end
    cyc();
    checks++; if (ifu_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL fu_c1 got=%b exp=1", ifu_icb_cmd_ready); end
    cyc();
    checks++; if (ifu_icb_cmd_ready !== 1'b0) begin errors++; $display("FAIL fu_c2_rdy got=%b exp=0", ifu_icb_cmd_ready); end
    checks++; if (itcm_icb_cmd_valid !== 1'b0) begin errors++; $display("FAIL fu_c2_vld got=%b exp=0", itcm_icb_cmd_valid); end
    cyc();
    itcm_icb_rsp_valid = 1'b1;
    #1;
    checks++; if (ifu_icb_cmd_ready !== 1'b0) begin errors++; $display("FAIL fu_pop_blk got=%b exp=0", ifu_icb_cmd_ready); end
    checks++; if (itcm_icb_rsp_ready !== 1'b1) begin errors++; $display("FAIL fu_pop_rdy got=%b exp=1", itcm_icb_rsp_ready); end
    cyc();
    checks++; if (ifu_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL fu_c3_acc got=%b exp=1", ifu_icb_cmd_ready); end
    checks++; if (ifu_icb_rsp_valid !== 1'b1) begin errors++; $display("FAIL fu_rsp2 got=%b exp=1", ifu_icb_rsp_valid); end
    cyc();
    ifu_icb_cmd_valid = 1'b0;
    #1;
    checks++; if (ifu_icb_rsp_valid !== 1'b1) begin errors++; $display("FAIL fu_rsp3 got=%b exp=1", ifu_icb_rsp_valid); end
    cyc();
    checks++; if (ifu_icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL fu_stray_v got=%b exp=0", ifu_icb_rsp_valid); end
    checks++; if (itcm_icb_rsp_ready !== 1'b0) begin errors++; $display("FAIL fu_stray_r got=%b exp=0", itcm_icb_rsp_ready); end
    idle();
  endtask

  task automatic test_write();
    idle();
    lsu_icb_cmd_valid  = 1'b1;
    lsu_icb_cmd_read   = 1'b0;
    lsu_icb_cmd_addr   = 16'h0100;
    lsu_icb_cmd_wdata  = 64'hDEADBEEF_00000000;
    lsu_icb_cmd_wmask  = 8'hF0;
    itcm_icb_cmd_ready = 1'b1;
    #1;
    checks++; if (lsu_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_rdy got=%b exp=1", lsu_icb_cmd_ready); end
    checks++; if (itcm_icb_cmd_addr !== 16'h0100) begin errors++; $display("FAIL wr_addr got=%h exp=0100", itcm_icb_cmd_addr); end
    checks++; if (itcm_icb_cmd_read !== 1'b0) begin errors++; $display("FAIL wr_read got=%b exp=0", itcm_icb_cmd_read); end
    checks++; if (itcm_icb_cmd_wdata !== 64'hDEADBEEF_00000000) begin errors++; $display("FAIL wr_wdata got=%h", itcm_icb_cmd_wdata); end
    checks++; if (itcm_icb_cmd_wmask !== 8'hF0) begin errors++; $display("FAIL wr_wmask got=%h exp=f0", itcm_icb_cmd_wmask); end
    cyc();
    lsu_icb_cmd_valid  = 1'b0;
    lsu_icb_rsp_ready  = 1'b1;
    ifu_icb_rsp_ready  = 1'b1;
    ifu_icb_cmd_valid  = 1'b1;
    ifu_icb_cmd_addr   = 16'h0100;
    itcm_icb_rsp_valid = 1'b1;
    itcm_icb_rsp_rdata = 64'h55;
    #1;
    checks++; if (ifu_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_rdy got=%b exp=1", ifu_icb_cmd_ready); end
    checks++; if (itcm_icb_cmd_read !== 1'b1) begin errors++; $display("FAIL rd_read got=%b exp=1", itcm_icb_cmd_read); end
    checks++; if (itcm_icb_cmd_wmask !== 8'h00) begin errors++; $display("FAIL rd_wmask got=%h exp=00", itcm_icb_cmd_wmask); end
    checks++; if (itcm_icb_cmd_wdata !== 64'h0) begin errors++; $display("FAIL rd_wdata got=%h exp=0", itcm_icb_cmd_wdata); end
    checks++; if (lsu_icb_rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rspv got=%b exp=1", lsu_icb_rsp_valid); end
    checks++; if (ifu_icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_ifu_rspv got=%b exp=0", ifu_icb_rsp_valid); end
    cyc();
    ifu_icb_cmd_valid = 1'b0;
    #1;
    checks++; if (ifu_icb_rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rspv got=%b exp=1", ifu_icb_rsp_valid); end
    cyc();
    idle();
  endtask

  task automatic test_rsp_backpressure();
    idle();
    lsu_icb_rsp_ready  = 1'b1;
    ifu_icb_cmd_valid  = 1'b1;
    itcm_icb_cmd_ready = 1'b1;
    #1;
    checks++; if (ifu_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_cmd got=%b exp=1", ifu_icb_cmd_ready); end
    cyc();
    ifu_icb_cmd_valid  = 1'b0;
    itcm_icb_rsp_valid = 1'b1;
    itcm_icb_rsp_err   = 1'b1;
    #1;
    checks++; if (itcm_icb_rsp_ready !== 1'b0) begin errors++; $display("FAIL bp_rdy0 got=%b exp=0", itcm_icb_rsp_ready); end
    checks++; if (lsu_icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_lsu_v got=%b exp=0", lsu_icb_rsp_valid); end
    checks++; if (ifu_icb_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_ifu_v got=%b exp=1", ifu_icb_rsp_valid); end
    cyc();
    ifu_icb_rsp_ready = 1'b1;
    #1;
    checks++; if (ifu_icb_rsp_err !== 1'b1) begin errors++; $display("FAIL bp_err got=%b exp=1", ifu_icb_rsp_err); end
    checks++; if (itcm_icb_rsp_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy1 got=%b exp=1", itcm_icb_rsp_ready); end
    cyc();
    checks++; if (ifu_icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_popped got=%b exp=0", ifu_icb_rsp_valid); end
    idle();
  endtask

  task automatic test_reset_midop();
    idle();
    ifu_icb_cmd_valid  = 1'b1;
    lsu_icb_cmd_valid  = 1'b1;
    itcm_icb_cmd_ready = 1'b1;
    #1;
    checks++; if (lsu_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL mr_tie_lsu got=%b exp=1", lsu_icb_cmd_ready); end
    cyc();
    lsu_icb_cmd_valid = 1'b0;
    #1;
    checks++; if (ifu_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL mr_ifu got=%b exp=1", ifu_icb_cmd_ready); end
    cyc();
    checks++; if (ifu_icb_cmd_ready !== 1'b0) begin errors++; $display("FAIL mr_full got=%b exp=0", ifu_icb_cmd_ready); end
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ifu_icb_cmd_valid  = 1'b1;
    lsu_icb_cmd_valid  = 1'b1;
    itcm_icb_cmd_ready = 1'b1;
    ifu_icb_rsp_ready  = 1'b1;
    lsu_icb_rsp_ready  = 1'b1;
    itcm_icb_rsp_valid = 1'b1;
    #1;
    checks++; if (ifu_icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_ifu_rspv got=%b exp=0", ifu_icb_rsp_valid); end
    checks++; if (lsu_icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_lsu_rspv got=%b exp=0", lsu_icb_rsp_valid); end
    checks++; if (itcm_icb_rsp_ready !== 1'b0) begin errors++; $display("FAIL mr_rsp_rdy got=%b exp=0", itcm_icb_rsp_ready); end
    checks++; if (ifu_icb_cmd_ready !== 1'b1) begin errors++; $display("FAIL mr_tie_ifu got=%b exp=1", ifu_icb_cmd_ready); end
    checks++; if (lsu_icb_cmd_ready !== 1'b0) begin errors++; $display("FAIL mr_tie_nolsu got=%b exp=0", lsu_icb_cmd_ready); end
    cyc();
    ifu_icb_cmd_valid = 1'b0;
    lsu_icb_cmd_valid = 1'b0;
    #1;
    checks++; if (ifu_icb_rsp_valid !== 1'b1) begin errors++; $display("FAIL mr_post_rsp got=%b exp=1", ifu_icb_rsp_valid); end
    cyc();
    idle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_write();
    test_rsp_backpressure();
    test_reset_midop();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
